// File: rtl/bp_stats_pkg.sv
// Shared constants for the branch-prediction statistics MMIO block:
// register offsets, CTRL bit positions and counter width.
package bp_stats_pkg;

   localparam int CNT_W = 32;

   localparam logic [3:0] OFF_CTRL   = 4'd0;
   localparam logic [3:0] OFF_ID     = 4'd1;
   localparam logic [3:0] OFF_BR_LO  = 4'd2;
   localparam logic [3:0] OFF_BR_HI  = 4'd3;
   localparam logic [3:0] OFF_HIT_LO = 4'd4;
   localparam logic [3:0] OFF_HIT_HI = 4'd5;
   localparam logic [3:0] OFF_MIS_LO = 4'd6;
   localparam logic [3:0] OFF_MIS_HI = 4'd7;
   localparam logic [3:0] OFF_CYC_LO = 4'd8;
   localparam logic [3:0] OFF_CYC_HI = 4'd9;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_FREEZE  = 1;
   localparam int CTRL_CLR     = 2;
   localparam int CTRL_SAT_LSB = 4;

endpackage

// File: rtl/sat_cnt32.sv
// 32-bit saturating up-counter with synchronous clear and a sticky
// saturation flag that rises on the edge the counter reaches all-ones.
module sat_cnt32
   import bp_stats_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] q,
   output logic             sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             sat_d, sat_q;

   // Clear has priority over an increment arriving in the same cycle.
   always_comb begin
      cnt_d = cnt_q;
      sat_d = sat_q;
      if (clr) begin
         cnt_d = '0;
         sat_d = 1'b0;
      end else begin
         if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
         end
         sat_d = sat_q | (cnt_d == CNT_MAX);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sat_q <= sat_d;
      end
   end

   assign q   = cnt_q;
   assign sat = sat_q;

endmodule

// File: rtl/bp_stats_mmio.sv
// Branch-prediction statistics block: four saturating counters behind a
// 16-word MMIO window with zero-latency reads and a LO->HI snapshot shadow.
module bp_stats_mmio
   import bp_stats_pkg::*;
#(
   parameter logic [15:0] BASE   = 16'hC000,
   parameter logic [15:0] ID_VAL = 16'hB7B0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] addr,
   input  logic        mm_re,
   input  logic        mm_we,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   input  logic        inc_br_cnt,
   input  logic        inc_hit_cnt,
   input  logic        inc_mispr_cnt
);

   logic             sel, rd_hit, wr_hit, ctrl_wr, clr, cnt_en;
   logic [3:0]       off;
   logic             en_d, en_q, frz_d, frz_q;
   logic [15:0]      shadow_d, shadow_q;
   logic [CNT_W-1:0] br_q, hit_q, mis_q, cyc_q;
   logic             sat_br, sat_hit, sat_mis, sat_cyc;
   logic [15:0]      ctrl_val;
   logic             unused_wdata;

   assign sel     = (addr[15:4] == BASE[15:4]);
   assign off     = addr[3:0];
   assign rd_hit  = sel & mm_re;
   assign wr_hit  = sel & mm_we;
   assign ctrl_wr = wr_hit & (off == OFF_CTRL);
   assign clr     = ctrl_wr & wdata[CTRL_CLR];
   assign cnt_en  = en_q & ~frz_q;

   assign unused_wdata = ^wdata[15:3];

   assign ctrl_val = {8'h00, sat_cyc, sat_mis, sat_hit, sat_br, 2'b00, frz_q, en_q};

   sat_cnt32 u_br  (.clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc_br_cnt & cnt_en),
                    .q(br_q), .sat(sat_br));
   sat_cnt32 u_hit (.clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc_hit_cnt & cnt_en),
                    .q(hit_q), .sat(sat_hit));
   sat_cnt32 u_mis (.clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc_mispr_cnt & cnt_en),
                    .q(mis_q), .sat(sat_mis));
   sat_cnt32 u_cyc (.clk(clk), .rst_n(rst_n), .clr(clr), .inc(cnt_en),
                    .q(cyc_q), .sat(sat_cyc));

   // A LO read latches the pre-increment high half so the HI read pairs with it.
   always_comb begin
      en_d     = en_q;
      frz_d    = frz_q;
      shadow_d = shadow_q;
      if (ctrl_wr) begin
         en_d  = wdata[CTRL_EN];
         frz_d = wdata[CTRL_FREEZE];
      end
      if (clr) begin
         shadow_d = '0;
      end else if (rd_hit) begin
         case (off)
            OFF_BR_LO:  shadow_d = br_q[31:16];
            OFF_HIT_LO: shadow_d = hit_q[31:16];
            OFF_MIS_LO: shadow_d = mis_q[31:16];
            OFF_CYC_LO: shadow_d = cyc_q[31:16];
            default:    shadow_d = shadow_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q     <= 1'b1;
         frz_q    <= 1'b0;
         shadow_q <= '0;
      end else begin
         en_q     <= en_d;
         frz_q    <= frz_d;
         shadow_q <= shadow_d;
      end
   end

   always_comb begin
      rdata = 16'h0000;
      if (rd_hit) begin
         case (off)
            OFF_CTRL:   rdata = ctrl_val;
            OFF_ID:     rdata = ID_VAL;
            OFF_BR_LO:  rdata = br_q[15:0];
            OFF_HIT_LO: rdata = hit_q[15:0];
            OFF_MIS_LO: rdata = mis_q[15:0];
            OFF_CYC_LO: rdata = cyc_q[15:0];
            OFF_BR_HI, OFF_HIT_HI, OFF_MIS_HI, OFF_CYC_HI:
                        rdata = shadow_q;
            default:    rdata = 16'h0000;
         endcase
      end
   end

endmodule
